// File: rtl/mux2_arb_if.sv
// Valid/ready bundle shared by two producers, the mux2_arb arbiter and its consumer.
// master = producer/consumer side, slave = arbiter side.
interface mux2_arb_if #(parameter int W = 8);
    logic         req0_valid;
    logic [W-1:0] req0_data;
    logic         req0_ready;
    logic         req1_valid;
    logic [W-1:0] req1_data;
    logic         req1_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic         sel;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, out_ready,
        input  req0_ready, req1_ready, out_valid, out_data, sel
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
        output req0_ready, req1_ready, out_valid, out_data, sel
    );
endinterface

// File: rtl/mux2_arb.sv
// Two-requester round-robin arbiter feeding one registered W-bit output slot.
// Optional per-requester saturating grant counters under `MUX2_ARB_CNT_EN.
module mux2_arb #(
    parameter int W  = 8,
    parameter int CW = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    mux2_arb_if.slave bus
`ifdef MUX2_ARB_CNT_EN
    ,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1
`endif
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t       state, state_nxt;
    logic [1:0]   vld;
    logic [1:0]   rdy;
    logic         g;
    logic         last;
    logic         sel_q;
    logic         load;
    logic         grant;
    logic [W-1:0] data_q;

    assign vld = {bus.req1_valid, bus.req0_valid};

    // Round robin only matters on a tie; otherwise the lone requester wins.
    always_comb begin
        g = 1'b0;
        case (vld)
            2'b10:   g = 1'b1;
            2'b11:   g = ~last;
            default: g = 1'b0;
        endcase
    end

    assign load  = (state == EMPTY) || bus.out_ready;
    // rst_n gating keeps both readys low while reset is held.
    assign grant = rst_n && load && (|vld);
    assign rdy   = {grant && g, grant && !g};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (load) state_nxt = (|vld) ? FULL : EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            sel_q  <= 1'b0;
            last   <= 1'b1;
        end else if (grant) begin
            data_q <= g ? bus.req1_data : bus.req0_data;
            sel_q  <= g;
            last   <= g;
        end
    end

    assign bus.req0_ready = rdy[0];
    assign bus.req1_ready = rdy[1];
    assign bus.out_valid  = (state == FULL);
    assign bus.out_data   = data_q;
    assign bus.sel        = sel_q;

`ifdef MUX2_ARB_CNT_EN
    logic [1:0][CW-1:0] cnt_q;

    for (genvar i = 0; i < 2; i++) begin : g_cnt
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                          cnt_q[i] <= '0;
            else if (rdy[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + 1'b1;
        end
    end

    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
`endif
endmodule

// File: tb/tb_mux2_arb.sv
// Bench for mux2_arb: directed vector table, reset/counter sequences, then
// random traffic against a one-slot scoreboard model.
module tb_mux2_arb;
    localparam int W  = 8;
    localparam int CW = 2;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    mux2_arb_if #(.W(W)) bus ();

`ifdef MUX2_ARB_CNT_EN
    logic [CW-1:0] cnt0, cnt1;
    mux2_arb #(.W(W), .CW(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .cnt0(cnt0), .cnt1(cnt1));
`else
    mux2_arb #(.W(W), .CW(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         r0v;
        logic [W-1:0] r0d;
        logic         r1v;
        logic [W-1:0] r1d;
        logic         ordy;
        logic         er0;
        logic         er1;
        logic         eov;
        logic [W-1:0] eod;
        logic         esel;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r0v, input logic [W-1:0] r0d, input logic r1v,
                         input logic [W-1:0] r1d, input logic ordy);
        bus.req0_valid = r0v;
        bus.req0_data  = r0d;
        bus.req1_valid = r1v;
        bus.req1_data  = r1d;
        bus.out_ready  = ordy;
    endtask

    // scoreboard model state
    bit           m_full;
    logic [W-1:0] m_data;
    bit           m_sel;
    bit           m_last;
    int           m_cnt[2];

    initial begin
        n_chk = 0;
        n_err = 0;

        // single word, ties, backpressure, drain
        vecs[0]  = '{1'b1, 8'hAA, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hAA, 1'b0};
        vecs[1]  = '{1'b1, 8'hAA, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1};
        vecs[2]  = '{1'b1, 8'hAA, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 1'b1, 8'hAA, 1'b0};
        vecs[3]  = '{1'b1, 8'hAA, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1};
        vecs[4]  = '{1'b1, 8'hAA, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 1'b1, 8'hAA, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 8'h53, 1'b1, 1'b0, 1'b1, 1'b1, 8'h53, 1'b1};
        vecs[6]  = '{1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h53, 1'b1};
        vecs[7]  = '{1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h53, 1'b1};
        vecs[8]  = '{1'b1, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0};

        // reset values, readys held low despite a pending request
        rst_n = 1'b0;
        drive(1'b1, 8'h77, 1'b1, 8'h66, 1'b1);
        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_sel", 32'(bus.sel), 32'd0);
        chk("rst_r0_ready", 32'(bus.req0_ready), 32'd0);
        chk("rst_r1_ready", 32'(bus.req1_ready), 32'd0);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].r0v, vecs[i].r0d, vecs[i].r1v, vecs[i].r1d, vecs[i].ordy);
            #1;
            chk($sformatf("v%0d_r0_ready", i), 32'(bus.req0_ready), 32'(vecs[i].er0));
            chk($sformatf("v%0d_r1_ready", i), 32'(bus.req1_ready), 32'(vecs[i].er1));
            @(posedge clk); #1;
            chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].eov));
            if (vecs[i].eov) begin
                chk($sformatf("v%0d_out_data", i), 32'(bus.out_data), 32'(vecs[i].eod));
                chk($sformatf("v%0d_sel", i), 32'(bus.sel), 32'(vecs[i].esel));
            end
        end

        // asynchronous reset with a word parked in the output register
        drive(1'b0, 8'h00, 1'b1, 8'h5C, 1'b0);
        @(posedge clk); #1;
        chk("mid_out_valid_pre", 32'(bus.out_valid), 32'd1);
        chk("mid_out_data_pre", 32'(bus.out_data), 32'h5C);
        drive(1'b1, 8'h12, 1'b0, 8'h00, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_out_data", 32'(bus.out_data), 32'd0);
        chk("mid_rst_sel", 32'(bus.sel), 32'd0);
        chk("mid_rst_r0_ready", 32'(bus.req0_ready), 32'd0);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

`ifdef MUX2_ARB_CNT_EN
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(i), 1'b0, 8'h00, 1'b1);
            @(posedge clk); #1;
            chk($sformatf("cnt0_step%0d", i), 32'(cnt0), (i < 3) ? 32'(i + 1) : 32'd3);
            chk($sformatf("cnt1_step%0d", i), 32'(cnt1), 32'd0);
        end
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
`endif

        // random traffic against the one-slot model
        m_full = 1'b0;
        m_data = '0;
        m_sel  = 1'b0;
        m_last = 1'b1;
        m_cnt  = '{0, 0};
        for (int c = 0; c < 400; c++) begin
            logic         r0v, r1v, ordy, can, gv, w;
            logic [W-1:0] d0, d1;
            r0v  = ($urandom_range(0, 99) < 60);
            r1v  = ($urandom_range(0, 99) < 60);
            ordy = ($urandom_range(0, 99) < 70);
            d0   = 8'($urandom);
            d1   = 8'($urandom);
            drive(r0v, d0, r1v, d1, ordy);
            #1;
            can = !m_full || ordy;
            gv  = can && (r0v || r1v);
            w   = (r0v && r1v) ? !m_last : r1v;
            chk("rnd_r0_ready", 32'(bus.req0_ready), 32'(gv && !w));
            chk("rnd_r1_ready", 32'(bus.req1_ready), 32'(gv && w));
            chk("rnd_out_valid", 32'(bus.out_valid), 32'(m_full));
            if (m_full) begin
                chk("rnd_out_data", 32'(bus.out_data), 32'(m_data));
                chk("rnd_sel", 32'(bus.sel), 32'(m_sel));
            end
`ifdef MUX2_ARB_CNT_EN
            chk("rnd_cnt0", 32'(cnt0), 32'(m_cnt[0]));
            chk("rnd_cnt1", 32'(cnt1), 32'(m_cnt[1]));
`endif
            @(posedge clk); #1;
            if (gv) begin
                m_full = 1'b1;
                m_data = w ? d1 : d0;
                m_sel  = w;
                m_last = w;
                if (m_cnt[w] < (1 << CW) - 1) m_cnt[w]++;
            end else if (m_full && ordy) begin
                m_full = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
